uart_echo_responder: RTL and testbench

//  Remote-end UART peer for the uart_top link: receives 8N1 frames on rx and echoes each good byte back on tx.

---
 rtl/uart_echo_responder.sv | 198 +++++++++++++++++++
 tb/tb_uart_echo_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: 8N1 UART receiver that echoes each good byte back on tx,
// buffered through a small FIFO so back-to-back frames survive a busy transmitter.
module uart_echo_responder #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx,
  input  logic                             echo_en,
  input  logic                             tx_hold,
  output logic                             tx,
  output logic                             tx_busy,
  output logic [7:0]                       rx_data,
  output logic                             rx_valid,
  output logic                             frame_err,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [FW-1:0] CNT1_FW  = FW'(1);
  localparam logic [FW-1:0] FULL_CNT = FW'(FIFO_DEPTH);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  rx_state_t       rx_state_r;
  tx_state_t       tx_state_r;
  logic            rx_meta_r, rxs_r;
  logic [CW-1:0]   rx_cnt_r, tx_cnt_r;
  logic [2:0]      rx_bit_r, tx_bit_r;
  logic [7:0]      rx_shift_r, tx_shift_r;
  logic            push_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic            pop_s, full_s, do_push_s;

  // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
  assign pop_s     = (tx_state_r == T_IDLE) && (fifo_count != '0) && !tx_hold;
  assign full_s    = (fifo_count == FULL_CNT);
  assign do_push_s = push_r && (!full_s || pop_s);

  // Two-flop synchronizer for the asynchronous rx line, idling high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // Receive FSM with registered byte, pulses and FIFO push request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r <= R_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      push_r     <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      push_r    <= 1'b0;
      case (rx_state_r)
        R_IDLE: if (!rxs_r) begin
          rx_state_r <= R_START;
          rx_cnt_r   <= '0;
        end
        R_START: if (rx_cnt_r == CNT_HALF) begin
          rx_cnt_r   <= '0;
          rx_bit_r   <= 3'd0;
          rx_state_r <= rxs_r ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_r <= rx_cnt_r + CNT_ONE;
        end
        R_DATA: if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_r   <= '0;
          rx_shift_r <= {rxs_r, rx_shift_r[7:1]};
          rx_bit_r   <= rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_r <= R_STOP;
        end else begin
          rx_cnt_r <= rx_cnt_r + CNT_ONE;
        end
        R_STOP: if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_r <= '0;
          if (rxs_r) begin
            rx_data    <= rx_shift_r;
            rx_valid   <= 1'b1;
            push_r     <= echo_en;
            rx_state_r <= R_IDLE;
          end else begin
            frame_err  <= 1'b1;
            rx_state_r <= R_WAIT_HIGH;
          end
        end else begin
          rx_cnt_r <= rx_cnt_r + CNT_ONE;
        end
        R_WAIT_HIGH: if (rxs_r) rx_state_r <= R_IDLE;
        default: rx_state_r <= R_IDLE;
      endcase
    end
  end

  // Echo buffer storage.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= rx_data;
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push_r && full_s && !pop_s;
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, pop_s})
        2'b10:   fifo_count <= fifo_count + CNT1_FW;
        2'b01:   fifo_count <= fifo_count - CNT1_FW;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmit FSM; tx and tx_busy are registered directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_r <= T_IDLE;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      case (tx_state_r)
        T_IDLE: begin
          tx <= 1'b1;
          if (pop_s) begin
            tx_shift_r <= mem_r[rd_ptr_r];
            tx         <= 1'b0;
            tx_busy    <= 1'b1;
            tx_cnt_r   <= '0;
            tx_state_r <= T_START;
          end
        end
        T_START: if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_r   <= '0;
          tx_bit_r   <= 3'd0;
          tx         <= tx_shift_r[0];
          tx_state_r <= T_DATA;
        end else begin
          tx_cnt_r <= tx_cnt_r + CNT_ONE;
        end
        T_DATA: if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_r <= '0;
          if (tx_bit_r == 3'd7) begin
            tx         <= 1'b1;
            tx_state_r <= T_STOP;
          end else begin
            tx         <= tx_shift_r[1];
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_bit_r   <= tx_bit_r + 3'd1;
          end
        end else begin
          tx_cnt_r <= tx_cnt_r + CNT_ONE;
        end
        T_STOP: if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_r   <= '0;
          tx_busy    <= 1'b0;
          tx_state_r <= T_IDLE;
        end else begin
          tx_cnt_r <= tx_cnt_r + CNT_ONE;
        end
        default: begin
          tx         <= 1'b1;
          tx_busy    <= 1'b0;
          tx_state_r <= T_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: a frame-level reference model predicts every output
// each cycle; a tx decoder and directed scenarios pin the model with literal values.
module tb_uart_echo_responder;
  localparam int CPB    = 1000000 / 9600;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CPB;
  localparam int RX_LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, echo_en = 1'b1, tx_hold = 1'b0;
  logic       tx, tx_busy, rx_valid, frame_err, overflow;
  logic [7:0] rx_data;
  logic [2:0] fifo_count;

  uart_echo_responder #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .echo_en(echo_en), .tx_hold(tx_hold),
    .tx(tx), .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Frames sent on rx: the edge at which the stop bit is judged, byte, and stop-bit value.
  longint     exp_edge [256];
  logic [7:0] exp_byte [256];
  logic       exp_good [256];
  int         exp_wr = 0;

  longint     cyc = 0;
  int         exp_rd = 0;
  logic [7:0] mq[$];
  logic       push_pend = 1'b0;
  longint     tx_start = -1000000, tx_free = 0;
  logic [7:0] tx_byte = 8'h00;
  logic       m_tx = 1'b1, m_busy = 1'b0, m_valid = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk or posedge rst) begin : model_step
    logic   pop, full;
    longint d;
    int     k;
    if (rst) begin
      mq.delete();
      push_pend = 1'b0; tx_start = -1000000; tx_free = 0;
      m_tx = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0; m_data = 8'h00;
      exp_rd = exp_wr;
    end else begin
      cyc = cyc + 1;
      m_valid = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
      full = (mq.size() == DEPTH);
      pop  = (cyc >= tx_free) && (mq.size() != 0) && !tx_hold;
      if (pop) begin
        tx_byte  = mq.pop_front();
        tx_start = cyc;
        tx_free  = cyc + FRAME + 1;
      end
      if (push_pend) begin
        if (full && !pop) m_ovf = 1'b1;
        else mq.push_back(m_data);
      end
      push_pend = 1'b0;
      if (exp_rd != exp_wr && exp_edge[exp_rd] == cyc) begin
        if (exp_good[exp_rd]) begin
          m_valid = 1'b1; m_data = exp_byte[exp_rd]; push_pend = echo_en;
        end else begin
          m_ferr = 1'b1;
        end
        exp_rd = exp_rd + 1;
      end
      d = cyc - tx_start;
      if (d < FRAME) begin
        k = int'(d / CPB);
        m_busy = 1'b1;
        m_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_byte[k-1];
      end else begin
        m_busy = 1'b0; m_tx = 1'b1;
      end
    end
  end

  int cnt_valid = 0, cnt_ferr = 0, cnt_ovf = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid === 1'b1) cnt_valid = cnt_valid + 1;
      if (frame_err === 1'b1) cnt_ferr = cnt_ferr + 1;
      if (overflow === 1'b1) cnt_ovf = cnt_ovf + 1;
      if (tx_busy === 1'b1) busy_cnt = busy_cnt + 1;
    end
  end

  // Independent UART decoder on tx, sampling mid-bit.
  int         dec_cnt = 0, dec_n = 0;
  logic       dec_active = 1'b0;
  logic [9:0] dec_bits = '0;
  logic [7:0] dec_log [64];
  logic [9:0] dec_bits_log [64];
  always @(negedge clk) begin
    if (rst) dec_active = 1'b0;
    else if (!dec_active) begin
      if (tx == 1'b0) begin dec_active = 1'b1; dec_cnt = 0; end
    end else dec_cnt = dec_cnt + 1;
    if (!rst && dec_active && (dec_cnt % CPB) == CPB / 2) begin
      dec_bits[dec_cnt / CPB] = tx;
      if (dec_cnt / CPB == 9) begin
        dec_log[dec_n % 64]      = dec_bits[8:1];
        dec_bits_log[dec_n % 64] = dec_bits;
        dec_n = dec_n + 1;
        dec_active = 1'b0;
      end
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk = n_chk + 1;
    if (act !== exp_v) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    exp_edge[exp_wr] = cyc + RX_LAT;
    exp_byte[exp_wr] = b;
    exp_good[exp_wr] = stop_bit;
    exp_wr = exp_wr + 1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      tick(CPB);
    end
  endtask

  int v0, f0, o0, d0, b0;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          check("rst_tx", 32'(tx), 32'(1'b1));
          check("rst_tx_busy", 32'(tx_busy), 32'(1'b0));
          check("rst_fifo_count", 32'(fifo_count), 32'(3'd0));
          check("rst_rx_data", 32'(rx_data), 32'(8'h00));
          check("rst_pulses", 32'({rx_valid, frame_err, overflow}), 32'(3'b000));
        end else begin
          check("tx", 32'(tx), 32'(m_tx));
          check("tx_busy", 32'(tx_busy), 32'(m_busy));
          check("rx_valid", 32'(rx_valid), 32'(m_valid));
          check("rx_data", 32'(rx_data), 32'(m_data));
          check("frame_err", 32'(frame_err), 32'(m_ferr));
          check("overflow", 32'(overflow), 32'(m_ovf));
          check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        end
      end
    join_none

    tick(5);
    rst = 1'b0;
    tick(5);

    // Single echoed frame 0xA5.
    v0 = cnt_valid; d0 = dec_n; b0 = busy_cnt;
    send_frame(8'hA5, 1'b1);
    tick(1100);
    check("t1_rx_valid_cnt", 32'(cnt_valid - v0), 32'd1);
    check("t1_rx_data", 32'(rx_data), 32'h0000_00A5);
    check("t1_echo_cnt", 32'(dec_n - d0), 32'd1);
    check("t1_echo_byte", 32'(dec_log[d0]), 32'h0000_00A5);
    check("t1_tx_bits", 32'(dec_bits_log[d0]), 32'(10'b1101001010));
    check("t1_busy_len", 32'(busy_cnt - b0), 32'd1040);

    // Short low glitch is rejected.
    v0 = cnt_valid; f0 = cnt_ferr; d0 = dec_n;
    rx = 1'b0; tick(30); rx = 1'b1; tick(200);
    check("t2_rx_valid_cnt", 32'(cnt_valid - v0), 32'd0);
    check("t2_frame_err_cnt", 32'(cnt_ferr - f0), 32'd0);
    check("t2_fifo_count", 32'(fifo_count), 32'd0);
    check("t2_tx_idle", 32'(tx), 32'd1);

    // Bad stop bit with stuck-low line, then recovery.
    v0 = cnt_valid; f0 = cnt_ferr;
    send_frame(8'h3C, 1'b0);
    tick(500); rx = 1'b1; tick(20);
    check("t3_frame_err_cnt", 32'(cnt_ferr - f0), 32'd1);
    check("t3_rx_valid_cnt", 32'(cnt_valid - v0), 32'd0);
    check("t3_fifo_count", 32'(fifo_count), 32'd0);
    v0 = cnt_valid; d0 = dec_n;
    send_frame(8'h11, 1'b1);
    tick(1100);
    check("t3_good_rx_cnt", 32'(cnt_valid - v0), 32'd1);
    check("t3_echo_cnt", 32'(dec_n - d0), 32'd1);
    check("t3_echo_byte", 32'(dec_log[d0]), 32'h0000_0011);

    // Held transmitter, six frames into a four-entry buffer.
    o0 = cnt_ovf; d0 = dec_n;
    tx_hold = 1'b1;
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1);
    tick(10);
    check("t4_fifo_full", 32'(fifo_count), 32'd4);
    check("t4_overflow_cnt", 32'(cnt_ovf - o0), 32'd2);
    tx_hold = 1'b0;
    tick(4 * (FRAME + 1) + 200);
    check("t4_echo_cnt", 32'(dec_n - d0), 32'd4);
    for (int i = 0; i < 4; i++) check("t4_echo_byte", 32'(dec_log[d0 + i]), 32'(i + 1));
    check("t4_fifo_empty", 32'(fifo_count), 32'd0);

    // Echo disabled: reported only.
    v0 = cnt_valid; d0 = dec_n;
    echo_en = 1'b0;
    send_frame(8'h55, 1'b1);
    tick(1100);
    check("t5_rx_valid_cnt", 32'(cnt_valid - v0), 32'd1);
    check("t5_rx_data", 32'(rx_data), 32'h0000_0055);
    check("t5_fifo_count", 32'(fifo_count), 32'd0);
    check("t5_no_echo", 32'(dec_n - d0), 32'd0);
    echo_en = 1'b1;

    // Randomized traffic with random echo_en, tx_hold and occasional bad stops.
    for (int n = 0; n < 20; n++) begin
      logic good;
      echo_en = ($urandom_range(0, 3) != 0);
      tx_hold = ($urandom_range(0, 3) == 0);
      good    = ($urandom_range(0, 7) != 0);
      send_frame(8'($urandom), good);
      rx = 1'b1;
      tick(good ? $urandom_range(0, 300) : $urandom_range(5, 40));
    end
    tx_hold = 1'b0; echo_en = 1'b1;
    tick(5000);
    check("rand_drain", 32'(fifo_count), 32'd0);

    // Reset in the middle of a transmitted frame with bytes still queued.
    tx_hold = 1'b1;
    send_frame(8'hA1, 1'b1);
    send_frame(8'hA2, 1'b1);
    send_frame(8'hA3, 1'b1);
    tick(20);
    check("t6_queued", 32'(fifo_count), 32'd3);
    d0 = dec_n;
    tx_hold = 1'b0;
    tick(1 + 4 * CPB + 50);
    check("t6_in_frame", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_tx", 32'(tx), 32'd1);
    check("t6_rst_busy", 32'(tx_busy), 32'd0);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    tick(5);
    rst = 1'b0;
    tick(3000);
    check("t6_no_echo", 32'(dec_n - d0), 32'd0);
    check("t6_count_after", 32'(fifo_count), 32'd0);
    check("t6_tx_after", 32'(tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
